onboard_button_reader: RTL and testbench

Input-side companion to the on-board LED blinker: samples the four active-low on-board push buttons, synchronizes and debounces them, and classifies each press as short or long. Classified presses are queued in a small first-word-fall-through event FIFO with a valid/ready interface, so pattern-control logic can consume them. Runs on the internal HF oscillator clock under the global set/reset.

---
 rtl/onboard_button_reader_if.sv | 11 +
 rtl/onboard_button_reader.sv | 195 +++++++++++++++++++
 tb/tb_onboard_button_reader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/onboard_button_reader_if.sv
// Event stream from the button reader to pattern-control logic.
// This is a valid/ready channel that carries {button index, event code}.
interface onboard_button_reader_if;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_btn;
   logic [1:0] evt_code;

   modport master (output evt_valid, output evt_btn, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_btn, input evt_code, output evt_ready);
endinterface

// File: rtl/onboard_button_reader.sv
// Samples the four active-low on-board buttons, then synchronizes and debounces them.
// Each press is classified as short or long, and the resulting events are queued in a FWFT FIFO.
module onboard_button_reader #(
   parameter int DEBOUNCE_CYCLES = 4_500_000,
   parameter int LONG_CYCLES     = 450_000_000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                           osc_clk,
   input  logic                           gsrn,
   input  logic [3:0]                     btn_n,
   output logic [3:0]                     btn_level,
   output logic                           overflow,
   onboard_button_reader_if.master        evt_bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_MAX = HW'(LONG_CYCLES - 1);
   localparam logic [1:0] CODE_SHORT    = 2'b01;
   localparam logic [1:0] CODE_LONG     = 2'b10;
   localparam logic [1:0] CODE_LONG_REL = 2'b11;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRESSED = 2'd1, ST_LONG = 2'd2} cls_state_t;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [3:0]    sync1, sync2, s, db;
   logic [DW-1:0] dcnt [4];

   // Input synchronizer: idle (released) level is 1
   always_ff @(posedge osc_clk or negedge gsrn) begin
      if (!gsrn) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   // Debounce: a level change is accepted only after DEBOUNCE_CYCLES straight disagreeing cycles
   always_ff @(posedge osc_clk or negedge gsrn) begin
      if (!gsrn) begin
         db <= '0;
         for (int i = 0; i < 4; i++) dcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s[i] == db[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DCNT_MAX) begin
               db[i]   <= s[i];
               dcnt[i] <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   assign btn_level = db;

   cls_state_t    state_q [4];
   cls_state_t    state_d [4];
   logic [HW-1:0] hcnt_q  [4];
   logic [HW-1:0] hcnt_d  [4];
   logic [3:0]    emit;
   logic [1:0]    emit_code [4];

   always_ff @(posedge osc_clk or negedge gsrn) begin
      if (!gsrn) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= ST_IDLE;
            hcnt_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
      end
   end

   // Classifier: in PRESSED, a release is checked before the long threshold
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i]   = state_q[i];
         hcnt_d[i]    = hcnt_q[i];
         emit[i]      = 1'b0;
         emit_code[i] = CODE_SHORT;
         case (state_q[i])
            ST_IDLE: begin
               if (db[i]) begin
                  state_d[i] = ST_PRESSED;
                  hcnt_d[i]  = '0;
               end
            end
            ST_PRESSED: begin
               if (!db[i]) begin
                  emit[i]      = 1'b1;
                  emit_code[i] = CODE_SHORT;
                  state_d[i]   = ST_IDLE;
               end else if (hcnt_q[i] == HCNT_MAX) begin
                  emit[i]      = 1'b1;
                  emit_code[i] = CODE_LONG;
                  state_d[i]   = ST_LONG;
               end else begin
                  hcnt_d[i] = hcnt_q[i] + 1'b1;
               end
            end
            ST_LONG: begin
               if (!db[i]) begin
                  emit[i]      = 1'b1;
                  emit_code[i] = CODE_LONG_REL;
                  state_d[i]   = ST_IDLE;
               end
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end
   end

   logic [3:0]    slot_vld;
   logic [1:0]    slot_code [4];
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          pop, room, push;
   logic [1:0]    push_idx;
   logic [3:0]    push_data;

   // Arbiter: the lowest-index pending slot wins; a same-cycle pop frees room in a full FIFO
   always_comb begin
      pop      = evt_bus.evt_valid && evt_bus.evt_ready;
      room     = (count != CW'(FIFO_DEPTH)) || pop;
      push_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (slot_vld[i]) push_idx = 2'(i);
      end
      push      = room && (|slot_vld);
      push_data = {push_idx, slot_code[push_idx]};
   end

   // A slot that is being pushed this edge may be reloaded; otherwise a new event is dropped
   always_ff @(posedge osc_clk or negedge gsrn) begin
      if (!gsrn) begin
         slot_vld <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (emit[i]) begin
               if (!slot_vld[i] || (push && push_idx == 2'(i))) slot_vld[i] <= 1'b1;
               else overflow <= 1'b1;
            end else if (push && push_idx == 2'(i)) begin
               slot_vld[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge osc_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (emit[i] && (!slot_vld[i] || (push && push_idx == 2'(i)))) slot_code[i] <= emit_code[i];
      end
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge osc_clk or negedge gsrn) begin
      if (!gsrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head fields read as zero while the FIFO is empty so they are defined out of reset
   assign evt_bus.evt_valid = (count != '0);
   assign evt_bus.evt_btn   = evt_bus.evt_valid ? mem[rd_ptr][3:2] : 2'b00;
   assign evt_bus.evt_code  = evt_bus.evt_valid ? mem[rd_ptr][1:0] : 2'b00;

endmodule

// File: tb/tb_onboard_button_reader.sv
// Directed bench for onboard_button_reader with short debounce/long thresholds.
module tb_onboard_button_reader;

   logic       osc_clk = 1'b0;
   logic       gsrn;
   logic [3:0] btn_n;
   logic [3:0] btn_level;
   logic       overflow;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] ev_q [$];
   int         ev_cyc [$];

   onboard_button_reader_if evt_if();

   onboard_button_reader #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(32),
      .FIFO_DEPTH(4)
   ) dut (
      .osc_clk(osc_clk),
      .gsrn(gsrn),
      .btn_n(btn_n),
      .btn_level(btn_level),
      .overflow(overflow),
      .evt_bus(evt_if)
   );

   initial forever #5 osc_clk = ~osc_clk;

   always @(posedge osc_clk) cyc <= cyc + 1;

   // Record every accepted event; the pop itself happens on the following rising edge
   always @(negedge osc_clk) begin
      if (gsrn && evt_if.evt_valid && evt_if.evt_ready) begin
         ev_q.push_back({evt_if.evt_btn, evt_if.evt_code});
         ev_cyc.push_back(cyc);
      end
   end

   typedef struct {
      int         btn;
      int         hold;
      int         n;
      logic [3:0] e0;
      int         l0;
      logic [3:0] e1;
      int         l1;
   } pv_t;

   pv_t vec [6];

   task automatic tick();
      @(posedge osc_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] mask, input int hold, input int settle);
      btn_n = ~mask;
      repeat (hold) tick();
      btn_n = 4'hF;
      repeat (settle) tick();
   endtask

   task automatic clear_q();
      ev_q.delete();
      ev_cyc.delete();
   endtask

   initial begin
      int  k;
      bit  rose;
      logic [3:0] head;

      // Events are {btn, code}; latencies are measured from the first low sample.
      vec[0] = '{2,  20, 1, 4'h9, 27, 4'h0, 0};
      vec[1] = '{0,   3, 0, 4'h0,  0, 4'h0, 0};
      vec[2] = '{0,   4, 1, 4'h1, 11, 4'h0, 0};
      vec[3] = '{3,  32, 1, 4'hD, 39, 4'h0, 0};
      vec[4] = '{3,  33, 2, 4'hE, 39, 4'hF, 40};
      vec[5] = '{1, 100, 2, 4'h6, 39, 4'h7, 107};

      gsrn = 1'b0;
      btn_n = 4'hF;
      evt_if.evt_ready = 1'b0;
      repeat (3) tick();
      check("rst_valid", 32'(evt_if.evt_valid), 0);
      check("rst_btn", 32'(evt_if.evt_btn), 0);
      check("rst_code", 32'(evt_if.evt_code), 0);
      check("rst_level", 32'(btn_level), 0);
      check("rst_ovf", 32'(overflow), 0);
      gsrn = 1'b1;
      repeat (100) tick();
      check("idle_valid", 32'(evt_if.evt_valid), 0);
      check("idle_level", 32'(btn_level), 0);
      check("idle_ovf", 32'(overflow), 0);

      // Bounce rejection on button 0
      evt_if.evt_ready = 1'b1;
      clear_q();
      rose = 1'b0;
      repeat (10) begin
         btn_n[0] = 1'b0;
         repeat (3) begin
            tick();
            if (btn_level[0]) rose = 1'b1;
         end
         btn_n[0] = 1'b1;
         tick();
         if (btn_level[0]) rose = 1'b1;
      end
      repeat (8) begin
         tick();
         if (btn_level[0]) rose = 1'b1;
      end
      check("bounce_level", 32'(rose), 0);
      check("bounce_events", ev_q.size(), 0);
      btn_n[0] = 1'b0;
      repeat (5) tick();
      check("db_edge5", 32'(btn_level[0]), 0);
      tick();
      check("db_edge6", 32'(btn_level[0]), 1);
      btn_n[0] = 1'b1;
      repeat (20) tick();
      check("db_release_events", ev_q.size(), 1);
      if (ev_q.size() >= 1) check("db_release_evt", 32'(ev_q[0]), 32'h1);

      // Single-button press table
      for (int v = 0; v < 6; v++) begin
         clear_q();
         k = cyc + 1;
         press(4'(1 << vec[v].btn), vec[v].hold, 20);
         check($sformatf("vec%0d_count", v), ev_q.size(), vec[v].n);
         if (vec[v].n >= 1 && ev_q.size() >= 1) begin
            check($sformatf("vec%0d_evt0", v), 32'(ev_q[0]), 32'(vec[v].e0));
            check($sformatf("vec%0d_lat0", v), ev_cyc[0] - k, vec[v].l0);
         end
         if (vec[v].n >= 2 && ev_q.size() >= 2) begin
            check($sformatf("vec%0d_evt1", v), 32'(ev_q[1]), 32'(vec[v].e1));
            check($sformatf("vec%0d_lat1", v), ev_cyc[1] - k, vec[v].l1);
         end
         check($sformatf("vec%0d_level", v), 32'(btn_level), 0);
      end

      // Simultaneous release of buttons 0, 1 and 3
      clear_q();
      k = cyc + 1;
      press(4'b1011, 10, 20);
      check("sim_count", ev_q.size(), 3);
      if (ev_q.size() == 3) begin
         check("sim_evt0", 32'(ev_q[0]), 32'h1);
         check("sim_evt1", 32'(ev_q[1]), 32'h5);
         check("sim_evt2", 32'(ev_q[2]), 32'hD);
         check("sim_lat0", ev_cyc[0] - k, 17);
         check("sim_lat1", ev_cyc[1] - k, 18);
         check("sim_lat2", ev_cyc[2] - k, 19);
      end

      // Backpressure: fill the FIFO, fill all slots, then drop a long press on button 0
      evt_if.evt_ready = 1'b0;
      clear_q();
      for (int b = 0; b < 4; b++) press(4'(1 << b), 6, 15);
      head = {evt_if.evt_btn, evt_if.evt_code};
      check("bp_valid", 32'(evt_if.evt_valid), 1);
      check("bp_head", 32'(head), 32'h1);
      press(4'hF, 6, 15);
      check("bp_slots_ovf", 32'(overflow), 0);
      check("bp_head_stable", 32'({evt_if.evt_btn, evt_if.evt_code}), 32'h1);
      press(4'h1, 40, 20);
      check("bp_ovf_set", 32'(overflow), 1);
      check("bp_none_popped", ev_q.size(), 0);
      evt_if.evt_ready = 1'b1;
      repeat (20) tick();
      check("drain_count", ev_q.size(), 8);
      if (ev_q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            logic [3:0] exp_e;
            exp_e = {2'(i % 4), 2'b01};
            check($sformatf("drain_evt%0d", i), 32'(ev_q[i]), 32'(exp_e));
         end
      end
      check("drain_empty", 32'(evt_if.evt_valid), 0);
      check("drain_ovf_sticky", 32'(overflow), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
